// File: rtl/nios_keys_in_pio_pkg.sv
// Shared register map for the key input PIO.
// The bench and the driver header generator use the same offsets.
package nios_keys_in_pio_pkg;

  localparam logic [1:0] KEYS_DATA = 2'd0;
  localparam logic [1:0] KEYS_MASK = 2'd1;
  localparam logic [1:0] KEYS_EDGE = 2'd2;
  localparam logic [1:0] KEYS_RSVD = 2'd3;

endpackage

// File: rtl/nios_keys_in_pio_if.sv
// Avalon-MM slave bus bundle for the key input PIO.
interface nios_keys_in_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/nios_keys_in_pio_debounce_bit.sv
// One key bit: 2-flop synchroniser, debounce counter, stable level and a
// registered one-cycle pulse on the selected transition.
module key_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 16,
  parameter logic RESET_BIT       = 1'b1,
  parameter bit   FALLING_EDGE    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic edge_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= RESET_BIT;
      sync2      <= RESET_BIT;
      stable     <= RESET_BIT;
      cnt        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      edge_pulse <= accept && (FALLING_EDGE ? !sync2 : sync2);
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios_keys_in_pio.sv
// Avalon-MM input PIO for the watch keys: debounced DATA, irq MASK and
// write-1-to-clear EDGE capture driving a registered level interrupt.
module nios_keys_in_pio
  import nios_keys_in_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1,
  parameter bit               FALLING_EDGE    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  nios_keys_in_pio_if.slave bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] pulse;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    key_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_BIT       (RESET_LEVEL[i]),
      .FALLING_EDGE    (FALLING_EDGE)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (in_port[i]),
      .stable     (stable[i]),
      .edge_pulse (pulse[i])
    );
  end

  assign wr = bus.chipselect && !bus.write_n;

  // A capture in the same cycle as its W1C clear wins, so no key event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr && bus.address == KEYS_MASK)
        mask_q <= bus.writedata[WIDTH-1:0];
      if (wr && bus.address == KEYS_EDGE)
        edge_q <= (edge_q & ~bus.writedata[WIDTH-1:0]) | pulse;
      else
        edge_q <= edge_q | pulse;
      irq <= |(edge_q & mask_q);
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      KEYS_DATA: bus.readdata[WIDTH-1:0] = stable;
      KEYS_MASK: bus.readdata[WIDTH-1:0] = mask_q;
      KEYS_EDGE: bus.readdata[WIDTH-1:0] = edge_q;
      default:   bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_keys_in_pio.sv
// Directed bench for the key input PIO with a short debounce window.
module tb_nios_keys_in_pio;
  import nios_keys_in_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_port = 4'hF;
  logic       irq;
  int         total = 0;
  int         bad = 0;

  nios_keys_in_pio_if bus ();

  nios_keys_in_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16),
    .RESET_LEVEL     (4'hF),
    .FALLING_EDGE    (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_write;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(name, bus.readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    bus.address = KEYS_DATA; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

    vecs[0] = '{1'b0, KEYS_DATA, 32'h0,        32'hF};
    vecs[1] = '{1'b0, KEYS_MASK, 32'h0,        32'h0};
    vecs[2] = '{1'b0, KEYS_EDGE, 32'h0,        32'h0};
    vecs[3] = '{1'b1, KEYS_MASK, 32'hFFFFFFFF, 32'hF};
    vecs[4] = '{1'b1, KEYS_MASK, 32'h00000005, 32'h5};
    vecs[5] = '{1'b1, KEYS_DATA, 32'h00000000, 32'hF};
    vecs[6] = '{1'b1, KEYS_RSVD, 32'hFFFFFFFF, 32'h0};
    vecs[7] = '{1'b1, KEYS_EDGE, 32'h0000000F, 32'h0};
    vecs[8] = '{1'b1, KEYS_MASK, 32'h00000000, 32'h0};

    // 1: reset state and register map
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("irq_idle", {31'b0, irq}, 32'h0);
    end
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_write) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, $sformatf("vec%0d", i), vecs[i].exp);
    end
    tick();
    check("irq_after_map", {31'b0, irq}, 32'h0);

    // 2: clean press on bit 0 (current post-edge point is edge 0)
    tick();
    in_port = 4'hE;
    repeat (5) tick();
    rd(KEYS_DATA, "data_edge5", 32'hF);
    tick();
    rd(KEYS_DATA, "data_edge6", 32'hE);
    rd(KEYS_EDGE, "edge_edge6", 32'h0);
    tick();
    rd(KEYS_EDGE, "edge_edge7", 32'h1);
    tick();
    check("irq_masked", {31'b0, irq}, 32'h0);

    // 3: bouncing bit 1
    in_port = 4'hE; repeat (2) tick();
    in_port = 4'hC; repeat (2) tick();
    in_port = 4'hE; repeat (2) tick();
    rd(KEYS_EDGE, "edge_during_bounce", 32'h1);
    in_port = 4'hC;
    repeat (5) tick();
    rd(KEYS_DATA, "bounce_data_s5", 32'hE);
    rd(KEYS_EDGE, "bounce_edge_s5", 32'h1);
    tick();
    rd(KEYS_DATA, "bounce_data_s6", 32'hC);
    tick();
    rd(KEYS_EDGE, "bounce_edge_s7", 32'h3);
    repeat (10) tick();
    rd(KEYS_EDGE, "bounce_edge_hold", 32'h3);
    wr(KEYS_EDGE, 32'h2);
    rd(KEYS_EDGE, "edge_w1c_bit1", 32'h1);

    // 4: mask and clear drive irq one edge later
    wr(KEYS_MASK, 32'h3);
    check("irq_at_mask_write", {31'b0, irq}, 32'h0);
    tick();
    check("irq_after_mask", {31'b0, irq}, 32'h1);
    wr(KEYS_EDGE, 32'h1);
    rd(KEYS_EDGE, "edge_cleared", 32'h0);
    check("irq_at_clear", {31'b0, irq}, 32'h1);
    tick();
    check("irq_after_clear", {31'b0, irq}, 32'h0);

    // 5: W1C collides with a bit 2 capture; the capture wins
    in_port = 4'h8;
    repeat (6) tick();
    rd(KEYS_EDGE, "edge_before_collide", 32'h0);
    wr(KEYS_EDGE, 32'h4);
    rd(KEYS_EDGE, "edge_set_wins", 32'h4);
    tick();
    check("irq_bit2_unmasked", {31'b0, irq}, 32'h0);
    wr(KEYS_EDGE, 32'h4);
    rd(KEYS_EDGE, "edge_bit2_cleared", 32'h0);

    // 6: reset while bit 3 is mid-debounce (cnt reaches 2 at edge 4)
    in_port = 4'h0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    rd(KEYS_DATA, "rst_data", 32'hF);
    rd(KEYS_EDGE, "rst_edge", 32'h0);
    rd(KEYS_MASK, "rst_mask", 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    rd(KEYS_EDGE, "post_rst_edge", 32'h0);
    rd(KEYS_DATA, "post_rst_data", 32'hF);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
